alu_result_fifo: RTL

- Buffers results produced by the 32-bit ALU: result word, qualified overflow flag and the 3-bit operation code.
- Presents them to the downstream writeback/register-file stage over a valid/ready handshake.
- Derives a zero flag per entry.
- Keeps a sticky overflow status and a saturating overflow-event counter for software/debug visibility.

---
 rtl/alu_result_fifo.sv | 110 +++++++++++
 1 files changed

// File: rtl/alu_result_fifo.sv
// Result FIFO between the ALU and the writeback stage.
// Each entry holds result, overflow, zero and opcode; sticky overflow status and an event counter are kept alongside.
module alu_result_fifo #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 4,
  parameter int ADDRBITS = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    in_result,
  input  logic                in_overflow,
  input  logic [2:0]          in_op,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    out_result,
  output logic                out_overflow,
  output logic                out_zero,
  output logic [2:0]          out_op,
  output logic [ADDRBITS:0]   count,
  input  logic                clear_sticky,
  output logic                sticky_overflow,
  output logic [7:0]          ovf_events
);

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             overflow;
    logic             zero;
    logic [2:0]       op;
  } fifoEntry;

  localparam logic [ADDRBITS:0] FullCount = (ADDRBITS+1)'(DEPTH);

  fifoEntry              storage [DEPTH];
  fifoEntry              headEntry;
  logic [ADDRBITS-1:0]   wrPtr;
  logic [ADDRBITS-1:0]   rdPtr;
  logic                  isFull;
  logic                  isEmpty;
  logic                  doPush;
  logic                  doPop;
  logic                  ovfEvent;

  // Handshake qualifiers come only from the registered occupancy, so there is no in-to-out path.
  assign isFull   = (count == FullCount);
  assign isEmpty  = (count == '0);
  assign in_ready = ~isFull;
  assign out_valid = ~isEmpty;
  assign doPush   = in_valid & ~isFull;
  assign doPop    = out_ready & ~isEmpty;
  assign ovfEvent = doPush & in_overflow;

  // Storage needs no reset: an empty FIFO masks whatever it holds.
  always_ff @(posedge clk) begin
    if (doPush) begin
      storage[wrPtr] <= '{result:   in_result,
                          overflow: in_overflow,
                          zero:     (in_result == '0),
                          op:       in_op};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + ADDRBITS'(1);
      if (doPop)  rdPtr <= rdPtr + ADDRBITS'(1);
      if (doPush && !doPop)      count <= count + (ADDRBITS+1)'(1);
      else if (doPop && !doPush) count <= count - (ADDRBITS+1)'(1);
    end
  end

  // Head presentation; forced to zero while empty so stale storage never leaks out.
  always_comb begin
    headEntry    = storage[rdPtr];
    out_result   = '0;
    out_overflow = 1'b0;
    out_zero     = 1'b0;
    out_op       = '0;
    if (!isEmpty) begin
      out_result   = headEntry.result;
      out_overflow = headEntry.overflow;
      out_zero     = headEntry.zero;
      out_op       = headEntry.op;
    end
  end

  // A new overflow event beats a simultaneous clear: the count restarts at one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sticky_overflow <= 1'b0;
      ovf_events      <= 8'd0;
    end else if (ovfEvent) begin
      sticky_overflow <= 1'b1;
      if (clear_sticky)
        ovf_events <= 8'd1;
      else if (ovf_events != 8'hFF)
        ovf_events <= ovf_events + 8'd1;
    end else if (clear_sticky) begin
      sticky_overflow <= 1'b0;
      ovf_events      <= 8'd0;
    end
  end

endmodule
